vga_clk_lock_ctrl: RTL and testbench

Sequencer for the pixel-clock MMCM that produces 25.175 MHz from the 100 MHz board clock. It runs on the 100 MHz input clock and does five things: drives the MMCM reset, waits for lock, enforces a stability window, and only then asserts `clk_ready` to the VGA timing logic. It also detects lock loss and retries a bounded number of times before declaring failure.

---
 rtl/vga_clk_lock_ctrl.sv | 169 ++++++++++++++++
 tb/tb_vga_clk_lock_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_clk_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_clk_lock_ctrl
//  Purpose  : Bring-up sequencer for the 25.175 MHz pixel-clock MMCM. Pulses
//             the MMCM reset, waits for lock, requires a stability window
//             before raising clk_ready, and retries a bounded number of times
//             before latching a failure. Lock losses while running re-trigger
//             the sequence.
//  Options  : VGA_CLK_LOSS_CNT_EN - enables the saturating lock-loss counter
//             (otherwise loss_cnt reads as zero).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_clk_lock_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 17
) (
  input  logic       clk_in1,
  input  logic       resetn,
  input  logic       locked,
  input  logic       restart,
  output logic       mmcm_rst,
  output logic       clk_ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam logic [2:0] c_ST_RST    = 3'd0;
  localparam logic [2:0] c_ST_WAIT   = 3'd1;
  localparam logic [2:0] c_ST_STABLE = 3'd2;
  localparam logic [2:0] c_ST_RUN    = 3'd3;
  localparam logic [2:0] c_ST_FAIL   = 3'd4;

  localparam logic [CNT_W-1:0] c_RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
  localparam logic [3:0]       c_MAX_RETRY   = 4'(MAX_RETRY);

  logic [1:0]       sync_q;
  logic             locked_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             clk_ready_q, clk_ready_d;
  logic             fail_q, fail_d;
  logic             xfer;

  // Two-flop synchronizer for the asynchronous MMCM lock indication
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], locked};
  end

  assign locked_s = sync_q[1];

  // State, counters and registered outputs
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= c_ST_RST;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      mmcm_rst_q  <= 1'b1;
      clk_ready_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      mmcm_rst_q  <= mmcm_rst_d;
      clk_ready_q <= clk_ready_d;
      fail_q      <= fail_d;
    end
  end

  // Next-state, retry bookkeeping and the shared cycle counter
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (restart) begin
      state_d = c_ST_RST;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        c_ST_RST: begin
          if (cnt_q == c_RST_LAST) state_d = c_ST_WAIT;
        end
        c_ST_WAIT: begin
          // A lock seen on the timeout cycle still counts as success
          if (locked_s) begin
            state_d = c_ST_STABLE;
          end else if (cnt_q == c_LOCK_LAST) begin
            if (retry_q == c_MAX_RETRY) begin
              state_d = c_ST_FAIL;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = c_ST_RST;
            end
          end
        end
        c_ST_STABLE: begin
          // A dropout here is a glitch, not a failed attempt
          if (!locked_s)                   state_d = c_ST_WAIT;
          else if (cnt_q == c_STABLE_LAST) state_d = c_ST_RUN;
        end
        c_ST_RUN: begin
          if (!locked_s) begin
            state_d = c_ST_RST;
            retry_d = 4'd0;
          end
        end
        c_ST_FAIL: begin
          state_d = c_ST_FAIL;
        end
        default: begin
          state_d = c_ST_RST;
        end
      endcase
    end

    // Restart clears the counter even though RST may be re-entered from RST
    xfer = restart || (state_d != state_q);
    if (xfer) begin
      cnt_d = '0;
    end else if ((state_q == c_ST_RUN) || (state_q == c_ST_FAIL)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + c_CNT_ONE;
    end
  end

  // Outputs decoded from the next state so they move with the state register
  always_comb begin
    mmcm_rst_d  = (state_d == c_ST_RST) || (state_d == c_ST_FAIL);
    clk_ready_d = (state_d == c_ST_RUN);
    fail_d      = (state_d == c_ST_FAIL);
  end

`ifdef VGA_CLK_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_inc;

  // A loss is only counted when the RUN->RST exit actually happens
  assign loss_inc = (state_q == c_ST_RUN) && !locked_s && !restart;

  // Saturating lock-loss counter; survives restart, cleared only by reset
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn)                          loss_q <= 8'd0;
    else if (loss_inc && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign mmcm_rst  = mmcm_rst_q;
  assign clk_ready = clk_ready_q;
  assign fail      = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_clk_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_clk_lock_ctrl
//  Purpose  : Self-checking bench for vga_clk_lock_ctrl with small timing
//             parameters. Expected output snapshots are queued as stimulus is
//             applied and compared once the DUT has advanced.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_clk_lock_ctrl;

`ifdef VGA_CLK_LOSS_CNT_EN
  localparam int LC_EN = 1;
`else
  localparam int LC_EN = 0;
`endif

  logic       clk_in1;
  logic       resetn;
  logic       locked;
  logic       restart;
  logic       mmcm_rst;
  logic       clk_ready;
  logic       fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_checks;
  int n_fail;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       mr;
    logic       cr;
    logic       fl;
    logic [3:0] rc;
    logic [7:0] lc;
  } exp_t;

  exp_t sb_q[$];

  vga_clk_lock_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (16),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2),
    .CNT_W        (5)
  ) dut (
    .clk_in1  (clk_in1),
    .resetn   (resetn),
    .locked   (locked),
    .restart  (restart),
    .mmcm_rst (mmcm_rst),
    .clk_ready(clk_ready),
    .fail     (fail),
    .state    (state),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt)
  );

  initial clk_in1 = 1'b0;
  always #5 clk_in1 = ~clk_in1;

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in1);
      #1;
    end
  endtask

  task automatic sb_pop_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({e.tag, ".state"},     32'(state),     32'(e.st));
      check_val({e.tag, ".mmcm_rst"},  32'(mmcm_rst),  32'(e.mr));
      check_val({e.tag, ".clk_ready"}, 32'(clk_ready), 32'(e.cr));
      check_val({e.tag, ".fail"},      32'(fail),      32'(e.fl));
      check_val({e.tag, ".retry_cnt"}, 32'(retry_cnt), 32'(e.rc));
      check_val({e.tag, ".loss_cnt"},  32'(loss_cnt),  32'(e.lc));
    end
  endtask

  // Queue an expected snapshot, advance n edges, then compare it
  task automatic expect_after(input string tag, input int n, input logic [2:0] st,
                              input logic mr, input logic cr, input logic fl,
                              input logic [3:0] rc, input int losses);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.mr  = mr;
    e.cr  = cr;
    e.fl  = fl;
    e.rc  = rc;
    e.lc  = 8'(LC_EN * losses);
    sb_q.push_back(e);
    tick(n);
    sb_pop_compare();
  endtask

  // Starts just after the edge that entered RST (cnt=0); ends on STABLE entry
  task automatic bring_up(input string tag, input int delay, input logic [3:0] rc, input int losses);
    expect_after({tag, ".rst_hold"}, 3, 3'd0, 1'b1, 1'b0, 1'b0, rc, losses);
    expect_after({tag, ".wait"},     1, 3'd1, 1'b0, 1'b0, 1'b0, rc, losses);
    tick(delay);
    locked = 1'b1;
    expect_after({tag, ".sync"},     2, 3'd1, 1'b0, 1'b0, 1'b0, rc, losses);
    expect_after({tag, ".stable"},   1, 3'd2, 1'b0, 1'b0, 1'b0, rc, losses);
  endtask

  task automatic stable_to_run(input string tag, input logic [3:0] rc, input int losses);
    expect_after({tag, ".stable_end"}, 7, 3'd2, 1'b0, 1'b0, 1'b0, rc, losses);
    expect_after({tag, ".run"},        1, 3'd3, 1'b0, 1'b1, 1'b0, rc, losses);
  endtask

  task automatic lose_lock(input string tag, input logic [3:0] rc, input int losses_after);
    locked = 1'b0;
    expect_after({tag, ".pending"}, 2, 3'd3, 1'b0, 1'b1, 1'b0, rc, losses_after - 1);
    expect_after({tag, ".rst"},     1, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, losses_after);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    locked   = 1'b0;
    restart  = 1'b0;

    tick(2);
    expect_after("reset", 0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 0);
    @(negedge clk_in1);
    resetn = 1'b1;

    // Normal bring-up: lock 10 cycles after mmcm_rst falls
    bring_up("norm", 10, 4'd0, 0);
    stable_to_run("norm", 4'd0, 0);

    // Lock loss while running
    lose_lock("loss1", 4'd0, 1);

    // Timeout and retry exhaustion with locked held low
    expect_after("to.wait0",   4, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1);
    expect_after("to.last0",  15, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1);
    expect_after("to.rst1",    1, 3'd0, 1'b1, 1'b0, 1'b0, 4'd1, 1);
    expect_after("to.wait1",   4, 3'd1, 1'b0, 1'b0, 1'b0, 4'd1, 1);
    expect_after("to.rst2",   16, 3'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1);
    expect_after("to.wait2",   4, 3'd1, 1'b0, 1'b0, 1'b0, 4'd2, 1);
    expect_after("to.last2",  15, 3'd1, 1'b0, 1'b0, 1'b0, 4'd2, 1);
    expect_after("to.fail",    1, 3'd4, 1'b1, 1'b0, 1'b1, 4'd2, 1);
    expect_after("to.hold",    6, 3'd4, 1'b1, 1'b0, 1'b1, 4'd2, 1);

    // Restart out of FAIL, then a normal bring-up
    restart = 1'b1;
    expect_after("restart", 1, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1);
    restart = 1'b0;
    bring_up("rs", 10, 4'd0, 1);
    stable_to_run("rs", 4'd0, 1);

    // Glitch in STABLE: drop lock 5 cycles in, for 3 cycles
    lose_lock("loss2", 4'd0, 2);
    bring_up("gl", 10, 4'd0, 2);
    tick(5);
    locked = 1'b0;
    expect_after("gl.late",  2, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 2);
    expect_after("gl.back",  1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 2);
    locked = 1'b1;
    expect_after("gl.sync",  2, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 2);
    expect_after("gl.stab",  1, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 2);
    stable_to_run("gl", 4'd0, 2);

    // Asynchronous reset in the middle of STABLE
    lose_lock("loss3", 4'd0, 3);
    bring_up("ar", 10, 4'd0, 3);
    tick(3);
    #3;
    resetn = 1'b0;
    #1;
    expect_after("async_rst", 0, 3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 0);
    locked = 1'b0;
    @(negedge clk_in1);
    resetn = 1'b1;

    // One timed-out attempt, then lock; loss in RUN clears retry_cnt
    expect_after("rt.wait0",  4, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    expect_after("rt.rst1",  16, 3'd0, 1'b1, 1'b0, 1'b0, 4'd1, 0);
    bring_up("rt", 10, 4'd1, 0);
    stable_to_run("rt", 4'd1, 0);
    lose_lock("loss4", 4'd1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
